// File: rtl/mux_rr_rtl.sv
// N-input registered multiplexer with valid/ready handshakes, round-robin or forced arbitration,
// and a single-entry output register that reloads on the same cycle it drains for full throughput.
module mux_rr_rtl #(
    parameter int nbits = 8,
    parameter int ninputs = 4,
    localparam int sbits = $clog2(ninputs)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ninputs-1:0]       in_val,
    output logic [ninputs-1:0]       in_rdy,
    input  logic [ninputs*nbits-1:0] in_msg,
    input  logic                     force_en,
    input  logic [sbits-1:0]         force_sel,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [nbits-1:0]         out_msg,
    output logic [sbits-1:0]         out_sel
);

    logic               full;
    logic [nbits-1:0]   msg_reg;
    logic [sbits-1:0]   sel_reg;
    logic [sbits-1:0]   ptr;

    logic [ninputs-1:0] grant;
    logic [sbits-1:0]   grant_idx;
    logic [nbits-1:0]   grant_msg;
    logic               found;
    logic [sbits:0]     idx;
    logic               can_enq;
    logic               xfer;

    assign out_val = full;
    assign out_msg = msg_reg;
    assign out_sel = sel_reg;

    assign can_enq = !full || out_rdy;
    assign in_rdy  = grant & {ninputs{can_enq && !rst}};
    assign xfer    = |in_rdy;

    // Round-robin scans channels starting at ptr; idx wraps by subtraction so non-power-of-2 counts work.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_msg = '0;
        found     = 1'b0;
        idx       = '0;
        if (force_en) begin
            for (int unsigned i = 0; i < ninputs; i++) begin
                if (force_sel == sbits'(i) && in_val[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = sbits'(i);
                    grant_msg = in_msg[i*nbits +: nbits];
                end
            end
        end else begin
            for (int unsigned j = 0; j < ninputs; j++) begin
                idx = {1'b0, ptr} + (sbits+1)'(j);
                if (idx >= (sbits+1)'(ninputs))
                    idx = idx - (sbits+1)'(ninputs);
                for (int unsigned i = 0; i < ninputs; i++) begin
                    if (!found && idx == (sbits+1)'(i) && in_val[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = sbits'(i);
                        grant_msg = in_msg[i*nbits +: nbits];
                        found     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 1'b0;
            msg_reg <= '0;
            sel_reg <= '0;
            ptr     <= '0;
        end else begin
            if (xfer) begin
                full    <= 1'b1;
                msg_reg <= grant_msg;
                sel_reg <= grant_idx;
                if (!force_en)
                    ptr <= (grant_idx == sbits'(ninputs - 1)) ? '0 : grant_idx + 1'b1;
            end else if (full && out_rdy) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_rtl.sv
// Bench for mux_rr_rtl: a 4-input instance driven from a vector table with a message scoreboard,
// and a 3-input instance exercising pointer wrap and out-of-range forced selection.
module tb_mux_rr_rtl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, fen4, ordy4, oval4;
    logic [3:0]  val4, rdy4;
    logic [31:0] msg4;
    logic [1:0]  fsel4, osel4;
    logic [7:0]  omsg4;

    logic        rst3, fen3, ordy3, oval3;
    logic [2:0]  val3, rdy3;
    logic [23:0] msg3;
    logic [1:0]  fsel3, osel3;
    logic [7:0]  omsg3;

    mux_rr_rtl #(.nbits(8), .ninputs(4)) u4 (
        .clk(clk), .rst(rst4), .in_val(val4), .in_rdy(rdy4), .in_msg(msg4),
        .force_en(fen4), .force_sel(fsel4), .out_val(oval4), .out_rdy(ordy4),
        .out_msg(omsg4), .out_sel(osel4)
    );

    mux_rr_rtl #(.nbits(8), .ninputs(3)) u3 (
        .clk(clk), .rst(rst3), .in_val(val3), .in_rdy(rdy3), .in_msg(msg3),
        .force_en(fen3), .force_sel(fsel3), .out_val(oval3), .out_rdy(ordy3),
        .out_msg(omsg3), .out_sel(osel3)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  val;
        logic [31:0] msg;
        logic        fen;
        logic [1:0]  fsel;
        logic        ordy;
        logic [3:0]  erdy;
        logic        eoval;
        logic [7:0]  eomsg;
        logic [1:0]  eosel;
    } vec_t;

    typedef struct {
        logic [7:0] msg;
        logic [1:0] sel;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] m,
                                input logic fe, input logic [1:0] fs, input logic ordy,
                                input logic [3:0] erdy, input logic eov, input logic [7:0] eom,
                                input logic [1:0] eos);
        vec_t t;
        t.rst = r; t.val = v; t.msg = m; t.fen = fe; t.fsel = fs; t.ordy = ordy;
        t.erdy = erdy; t.eoval = eov; t.eomsg = eom; t.eosel = eos;
        return t;
    endfunction

    task automatic step3(input string name, input logic r, input logic [2:0] v, input logic fe,
                         input logic [1:0] fs, input logic [2:0] erdy, input logic eov,
                         input logic [1:0] eos);
        @(negedge clk);
        rst3 = r; val3 = v; fen3 = fe; fsel3 = fs; ordy3 = 1'b1;
        #1;
        check({name, "_in_rdy"}, 32'(rdy3), 32'(erdy));
        @(posedge clk);
        #1;
        check({name, "_out_val"}, 32'(oval3), 32'(eov));
        check({name, "_out_sel"}, 32'(osel3), 32'(eos));
        check({name, "_out_msg"}, 32'(omsg3), r ? 32'h0 : 32'(8'hC0 + 8'(eos)));
    endtask

    localparam logic [31:0] M = 32'h33221100;

    initial begin
        rst4 = 1'b1; val4 = '0; msg4 = M; fen4 = 1'b0; fsel4 = '0; ordy4 = 1'b1;
        rst3 = 1'b1; val3 = '0; msg3 = 24'hC2C1C0; fen3 = 1'b0; fsel3 = '0; ordy3 = 1'b1;

        // reset with all channels valid
        vecs.push_back(mk(1, 4'b1111, M, 0, 0, 1, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk(1, 4'b1111, M, 0, 0, 1, 4'b0000, 0, 8'h00, 0));
        // round-robin fairness: 00,11,22,33,00
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b0001, 1, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b0100, 1, 8'h22, 2));
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b1000, 1, 8'h33, 3));
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b0001, 1, 8'h00, 0));
        // backpressure: ch2 sends A5, held for 3 cycles, then ch3 accepted as out_rdy rises
        vecs.push_back(mk(0, 4'b0100, 32'h33A51100, 0, 0, 1, 4'b0100, 1, 8'hA5, 2));
        vecs.push_back(mk(0, 4'b0100, 32'h33A51100, 0, 0, 0, 4'b0000, 1, 8'hA5, 2));
        vecs.push_back(mk(0, 4'b0100, 32'h33A51100, 0, 0, 0, 4'b0000, 1, 8'hA5, 2));
        vecs.push_back(mk(0, 4'b0100, 32'h33A51100, 0, 0, 0, 4'b0000, 1, 8'hA5, 2));
        vecs.push_back(mk(0, 4'b1000, 32'h77A51100, 0, 0, 1, 4'b1000, 1, 8'h77, 3));
        // forced channel 1, then channel 1 drops out
        vecs.push_back(mk(0, 4'b1011, M, 1, 1, 1, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk(0, 4'b1011, M, 1, 1, 1, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk(0, 4'b1001, M, 1, 1, 1, 4'b0000, 0, 8'h11, 1));
        vecs.push_back(mk(0, 4'b1001, M, 1, 1, 1, 4'b0000, 0, 8'h11, 1));
        // back to round-robin: ptr still 0 from before forced mode
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b0001, 1, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 0, 4'b0000, 1, 8'h00, 0));
        // mid-operation reset while holding 5A
        vecs.push_back(mk(0, 4'b0001, 32'h3322115A, 0, 0, 1, 4'b0001, 1, 8'h5A, 0));
        vecs.push_back(mk(0, 4'b0000, M, 0, 0, 0, 4'b0000, 1, 8'h5A, 0));
        vecs.push_back(mk(1, 4'b1111, M, 0, 0, 0, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, M, 0, 0, 1, 4'b0001, 1, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0000, M, 0, 0, 1, 4'b0000, 0, 8'h00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst4 = vecs[i].rst; val4 = vecs[i].val; msg4 = vecs[i].msg;
            fen4 = vecs[i].fen; fsel4 = vecs[i].fsel; ordy4 = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_in_rdy", i), 32'(rdy4), 32'(vecs[i].erdy));
            if (!vecs[i].rst && oval4 && ordy4) begin
                if (sb.size() == 0) begin
                    check($sformatf("v%0d_sb_nonempty", i), 32'(sb.size()), 32'd1);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check($sformatf("v%0d_sb_msg", i), 32'(omsg4), 32'(e.msg));
                    check($sformatf("v%0d_sb_sel", i), 32'(osel4), 32'(e.sel));
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (vecs[i].erdy[k] && vecs[i].val[k]) begin
                    sb_t p;
                    logic [31:0] m;
                    m = vecs[i].msg;
                    p.msg = m[k*8 +: 8];
                    p.sel = 2'(k);
                    sb.push_back(p);
                end
            end
            @(posedge clk);
            #1;
            if (vecs[i].rst) sb.delete();
            check($sformatf("v%0d_out_val", i), 32'(oval4), 32'(vecs[i].eoval));
            check($sformatf("v%0d_out_msg", i), 32'(omsg4), 32'(vecs[i].eomsg));
            check($sformatf("v%0d_out_sel", i), 32'(osel4), 32'(vecs[i].eosel));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // three-input instance: wrap from ptr=2 and out-of-range forced select
        step3("n3_rst",    1, 3'b111, 0, 0, 3'b000, 0, 0);
        step3("n3_ch1",    0, 3'b010, 0, 0, 3'b010, 1, 1);
        step3("n3_wrap0",  0, 3'b011, 0, 0, 3'b001, 1, 0);
        step3("n3_ptr1",   0, 3'b111, 0, 0, 3'b010, 1, 1);
        step3("n3_ch2",    0, 3'b111, 0, 0, 3'b100, 1, 2);
        step3("n3_ptr0",   0, 3'b111, 0, 0, 3'b001, 1, 0);
        step3("n3_fsel3",  0, 3'b111, 1, 3, 3'b000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
